riscv_multicycle_core: RTL and testbench
========================================

Name: riscv_multicycle_core

Overview:
- Parametrised multi-cycle RV64I-subset core; the successor to our single-cycle datapath.
- Executes one instruction over several cycles through a control FSM and reaches instruction/data memory through ready/valid handshake ports instead of combinational arrays.
- Owns the register file, immediate generation, ALU and PC update, and exposes debug outputs matching the single-cycle datapath (nextPC, ALUResult, instruction).

Parameters:
- XLEN, 64, datapath/register/address width (32 or 64).
- NREGS, 32, architectural register count (16 or 32); register index = low log2(NREGS) bits of each field.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  XLEN  fetch address (= PC)
- imem_ready  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  XLEN  data address (ALU result)
- dmem_wdata  out  XLEN  store data (rs2)
- dmem_ready  in  1  data access complete; dmem_rdata valid on loads
- dmem_rdata  in  XLEN  load data
- nextPC  out  XLEN  current PC
- instruction  out  32  latched instruction register (IR)
- ALUResult  out  XLEN  latched ALU output register
- retired  out  32  retired-instruction counter
- illegal  out  1  sticky illegal-opcode flag; core halted

Behaviour:
- Reset, asynchronous, immediate:
  - PC = RESET_PC; IR = 0; ALUResult = 0; retired = 0; illegal = 0.
  - All regs = 0; state = FETCH; imem_req = dmem_req = dmem_we = 0.
- Supported instructions:
  - R: add, sub, and, or (opcode 0110011; funct7[5] selects sub).
  - I: addi (0010011); ld (0000011, funct3 011).
  - S: sd (0100011).
  - B: beq (1100011).
  - Immediates are sign-extended to XLEN; B-immediate is shifted left 1.
- FSM: FETCH -> DECODE -> EXEC -> {MEM} -> WB -> FETCH; plus HALT.
- FETCH:
  - imem_req = 1 and imem_addr = PC, held stable until imem_ready.
  - On imem_ready: IR <= imem_rdata and go to DECODE. Zero-wait fetch costs 1 cycle.
- DECODE:
  - Latch rs1/rs2 values (A, B) and the immediate.
  - Unknown opcode or unsupported funct: illegal <= 1, go to HALT. PC, regs and retired are unchanged.
- EXEC:
  - ALUResult <= ALU(A, B-or-imm).
  - beq: ALUResult = A - B; if zero, PC <= PC + imm, else PC <= PC + 4; retired++; go to FETCH (branch = 3 cycles at zero wait).
  - ld/sd go to MEM; all others go to WB.
- MEM:
  - dmem_req = 1; dmem_we = 1 for sd; addr/wdata held stable until dmem_ready.
  - On ready:
    - sd: PC += 4, retired++, go to FETCH.
    - ld: latch load data, go to WB.
- WB:
  - rd <= ALUResult (or load data) unless rd = x0; PC += 4; retired++; go to FETCH.
  - Zero-wait ALU op = 4 cycles, ld = 5, sd = 4.
- Register reads of x0 always return 0; writes to x0 are discarded.
- Register writes occur only in WB, so no read/write hazard arises within an instruction.
- PC arithmetic wraps modulo 2^XLEN; retired wraps at 2^32.
- Requests are never withdrawn before ready; a ready arriving while the corresponding req is 0 is ignored.
- HALT:
  - No requests; all state frozen; only reset exits.
- Reset asserted mid-access drops imem_req/dmem_req asynchronously; the interrupted instruction does not retire.

Test Plan:
- Reset, then addi x1,x0,5 / addi x2,x0,-3 / add x3,x1,x2 with zero-wait imem -> x3 = 2, retired = 3, nextPC = 12 after 12 cycles.
- sub x4,x1,x2 (5, -3); and/or with 0xF0/0x3C -> x4 = 8; and = 0x30; or = 0xFC.
- sd x3,8(x0) then ld x5,8(x0), with dmem_ready delayed 3 cycles -> dmem_req, dmem_addr = 8 and dmem_wdata = 2 held stable through the wait; x5 = 2.
- beq x1,x1,-8 (taken) and beq x1,x2,+16 (not taken) -> PC = PC-8, then PC+4; each retires in 3 cycles.
- addi x0,x0,7 then add x6,x0,x0 -> x6 = 0; opcode 0x7F -> illegal = 1, no further imem_req, retired unchanged.
- Assert reset during a stalled MEM state; XLEN = 32, NREGS = 16 rerun of the first scenario -> outputs return to reset values immediately; 32-bit wrap of 0xFFFFFFFF + 1 = 0.

Source files
------------

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV64I-subset core (add/sub/and/or/addi/ld/sd/beq) with ready/valid
// instruction and data memory ports and single-cycle-datapath style debug outputs.
module riscv_multicycle_core #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] nextPC,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] ALUResult,
  output logic [31:0]     retired,
  output logic            illegal
);

  localparam int unsigned RW = $clog2(NREGS);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [XLEN-1:0] alu_q, alu_d, load_q, load_d;
  logic [31:0]     retired_q, retired_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] regs_q [NREGS];

  logic            rf_we;
  logic [XLEN-1:0] rf_wdata;

  logic [6:0]    opcode, funct7;
  logic [2:0]    funct3;
  logic [RW-1:0] rd, rs1, rs2;
  logic          is_r, is_addi, is_ld, is_sd, is_beq, r_ok, legal;
  logic [XLEN-1:0] imm, rs1_val, rs2_val, alu;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];
  assign rd     = ir_q[7 +: RW];
  assign rs1    = ir_q[15 +: RW];
  assign rs2    = ir_q[20 +: RW];

  assign is_r    = (opcode == 7'b0110011);
  assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_ld   = (opcode == 7'b0000011) && (funct3 == 3'b011);
  assign is_sd   = (opcode == 7'b0100011) && (funct3 == 3'b011);
  assign is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
  assign r_ok    = is_r && (((funct3 == 3'b000) && ((funct7 == 7'b0000000) ||
                                                     (funct7 == 7'b0100000))) ||
                            (((funct3 == 3'b111) || (funct3 == 3'b110)) &&
                             (funct7 == 7'b0000000)));
  assign legal   = r_ok || is_addi || is_ld || is_sd || is_beq;

  always_comb begin
    imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    if (opcode == 7'b0100011) begin
      imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    end else if (opcode == 7'b1100011) begin
      imm = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    end
  end

  // x0 is hard-wired to zero on the read side as well as being write-protected
  assign rs1_val = (rs1 == '0) ? '0 : regs_q[rs1];
  assign rs2_val = (rs2 == '0) ? '0 : regs_q[rs2];

  always_comb begin
    alu = a_q + imm_q;
    if (is_r) begin
      unique case (funct3)
        3'b111:  alu = a_q & b_q;
        3'b110:  alu = a_q | b_q;
        default: alu = funct7[5] ? (a_q - b_q) : (a_q + b_q);
      endcase
    end else if (is_beq) begin
      alu = a_q - b_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    alu_d     = alu_q;
    load_d    = load_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    rf_wdata  = alu_q;
    case (state_q)
      StFetch: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!legal) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else begin
          a_d     = rs1_val;
          b_d     = rs2_val;
          imm_d   = imm;
          state_d = StExec;
        end
      end
      StExec: begin
        alu_d = alu;
        if (is_beq) begin
          pc_d      = (alu == '0) ? (pc_q + imm_q) : (pc_q + XLEN'(4));
          retired_d = retired_q + 32'd1;
          state_d   = StFetch;
        end else if (is_ld || is_sd) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (dmem_ready) begin
          if (is_sd) begin
            pc_d      = pc_q + XLEN'(4);
            retired_d = retired_q + 32'd1;
            state_d   = StFetch;
          end else begin
            load_d  = dmem_rdata;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_we     = (rd != '0);
        rf_wdata  = is_ld ? load_q : alu_q;
        pc_d      = pc_q + XLEN'(4);
        retired_d = retired_q + 32'd1;
        state_d   = StFetch;
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      load_q    <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_q     <= alu_d;
      load_q    <= load_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rd] <= rf_wdata;
    end
  end

  // Requests are gated by reset so an in-flight access drops the moment reset rises
  assign imem_req    = (state_q == StFetch) && !reset;
  assign imem_addr   = pc_q;
  assign dmem_req    = (state_q == StMem) && !reset;
  assign dmem_we     = dmem_req && is_sd;
  assign dmem_addr   = alu_q;
  assign dmem_wdata  = b_q;
  assign nextPC      = pc_q;
  assign instruction = ir_q;
  assign ALUResult   = alu_q;
  assign retired     = retired_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core: a 64-bit/32-reg instance with a stallable
// data memory and a 32-bit/16-reg instance that starts at the top of the address space.
module tb_riscv_multicycle_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 64-bit instance
  logic        reset;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, illegal;
  logic [63:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, nextPC, ALUResult;
  logic [31:0] imem_rdata, instruction, retired;
  logic [31:0] prog [64];
  logic [63:0] dmem [8];
  int          dmem_delay;
  int          dcnt;

  assign imem_ready = imem_req;
  assign imem_rdata = prog[imem_addr[7:2]];
  assign dmem_ready = dmem_req && (dcnt == dmem_delay);
  assign dmem_rdata = dmem[dmem_addr[5:3]];

  always @(posedge clk) begin
    if (!dmem_req || dmem_ready) dcnt <= 0;
    else dcnt <= dcnt + 1;
    if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr[5:3]] <= dmem_wdata;
  end

  riscv_multicycle_core #(.XLEN(64), .NREGS(32), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .nextPC(nextPC), .instruction(instruction), .ALUResult(ALUResult),
    .retired(retired), .illegal(illegal)
  );

  // 32-bit instance
  logic        rst32;
  logic        imem_req32, imem_ready32, dmem_req32, dmem_we32, illegal32;
  logic        dmem_ready32;
  logic [31:0] imem_addr32, dmem_addr32, dmem_wdata32, dmem_rdata32, pc32, alu32;
  logic [31:0] imem_rdata32, instr32, ret32;
  logic [31:0] prog32 [16];

  assign imem_ready32 = imem_req32;
  assign imem_rdata32 = prog32[imem_addr32[5:2]];
  assign dmem_ready32 = 1'b0;
  assign dmem_rdata32 = '0;

  riscv_multicycle_core #(.XLEN(32), .NREGS(16), .RESET_PC(32'hFFFF_FFFC)) dut32 (
    .clk(clk), .reset(rst32),
    .imem_req(imem_req32), .imem_addr(imem_addr32), .imem_ready(imem_ready32),
    .imem_rdata(imem_rdata32),
    .dmem_req(dmem_req32), .dmem_we(dmem_we32), .dmem_addr(dmem_addr32),
    .dmem_wdata(dmem_wdata32), .dmem_ready(dmem_ready32), .dmem_rdata(dmem_rdata32),
    .nextPC(pc32), .instruction(instr32), .ALUResult(alu32),
    .retired(ret32), .illegal(illegal32)
  );

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    logic [31:0] v;
    v = {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    return v;
  endfunction

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [31:0] v;
    v = {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    return v;
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    logic [31:0] v;
    v = {imm[11:5], rs2[4:0], rs1[4:0], 3'b011, imm[4:0], 7'b0100011};
    return v;
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1);
    logic [31:0] v;
    v = {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  localparam logic [6:0] OpImm = 7'b0010011;
  localparam logic [6:0] OpLd  = 7'b0000011;

  initial begin
    reset      = 1'b1;
    rst32      = 1'b1;
    dmem_delay = 0;
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    for (int i = 0; i < 16; i++) prog32[i] = 32'h0;
    for (int i = 0; i < 8; i++) dmem[i] = 64'h0;

    prog[0]  = enc_i(5, 0, 0, 1, OpImm);        // addi x1,x0,5
    prog[1]  = enc_i(-3, 0, 0, 2, OpImm);       // addi x2,x0,-3
    prog[2]  = enc_r(0, 2, 1, 0, 3);            // add  x3,x1,x2
    prog[3]  = enc_r(32, 2, 1, 0, 4);           // sub  x4,x1,x2
    prog[4]  = enc_i(240, 0, 0, 7, OpImm);      // addi x7,x0,0xF0
    prog[5]  = enc_i(60, 0, 0, 8, OpImm);       // addi x8,x0,0x3C
    prog[6]  = enc_r(0, 8, 7, 7, 9);            // and  x9,x7,x8
    prog[7]  = enc_r(0, 8, 7, 6, 10);           // or   x10,x7,x8
    prog[8]  = enc_s(8, 3, 0);                  // sd   x3,8(x0)
    prog[9]  = enc_i(8, 0, 3, 5, OpLd);         // ld   x5,8(x0)
    prog[10] = enc_s(16, 5, 0);                 // sd   x5,16(x0)
    prog[11] = enc_b(12, 0, 0);                 // beq  x0,x0,+12 -> 56
    prog[12] = enc_b(16, 2, 1);                 // beq  x1,x2,+16 (not taken)
    prog[13] = enc_b(12, 0, 0);                 // beq  x0,x0,+12 -> 64
    prog[14] = enc_b(-8, 1, 1);                 // beq  x1,x1,-8 -> 48
    prog[16] = enc_i(7, 0, 0, 0, OpImm);        // addi x0,x0,7
    prog[17] = enc_r(0, 0, 0, 0, 6);            // add  x6,x0,x0
    prog[18] = enc_s(24, 6, 0);                 // sd   x6,24(x0)
    prog[19] = 32'h0000_007F;                   // illegal opcode

    prog32[15] = enc_i(5, 0, 0, 1, OpImm);      // addi x1,x0,5 at 0xFFFFFFFC
    prog32[0]  = enc_i(-3, 0, 0, 2, OpImm);     // addi x2,x0,-3
    prog32[1]  = enc_r(0, 18, 17, 0, 3);        // add x3,x17,x18 aliases x1,x2
    prog32[2]  = enc_i(-1, 0, 0, 4, OpImm);     // addi x4,x0,-1
    prog32[3]  = enc_i(1, 4, 0, 5, OpImm);      // addi x5,x4,1 wraps to 0

    #1;
    chk("rst_pc", nextPC, 64'h0);
    chk("rst_ir", {32'h0, instruction}, 64'h0);
    chk("rst_alu", ALUResult, 64'h0);
    chk("rst_ret", {32'h0, retired}, 64'h0);
    chk("rst_ill", {63'h0, illegal}, 64'h0);
    chk("rst_ireq", {63'h0, imem_req}, 64'h0);
    chk("rst_dreq", {62'h0, dmem_req, dmem_we}, 64'h0);

    @(negedge clk) reset = 1'b0;
    tick(12);
    chk("add_pc", nextPC, 64'd12);
    chk("add_ret", {32'h0, retired}, 64'd3);
    chk("add_alu", ALUResult, 64'd2);
    chk("add_ir", {32'h0, instruction}, {32'h0, enc_r(0, 2, 1, 0, 3)});
    tick(4);
    chk("sub_alu", ALUResult, 64'd8);
    tick(12);
    chk("and_alu", ALUResult, 64'h30);
    tick(4);
    chk("or_alu", ALUResult, 64'hFC);
    chk("or_pc", nextPC, 64'd32);

    dmem_delay = 3;
    tick(3);
    for (int k = 0; k < 4; k++) begin
      chk("sd_req", {63'h0, dmem_req}, 64'd1);
      chk("sd_we", {63'h0, dmem_we}, 64'd1);
      chk("sd_addr", dmem_addr, 64'd8);
      chk("sd_wdata", dmem_wdata, 64'd2);
      tick(1);
    end
    chk("sd_pc", nextPC, 64'd36);
    chk("sd_ret", {32'h0, retired}, 64'd9);
    chk("sd_reqdrop", {63'h0, dmem_req}, 64'd0);
    tick(3);
    chk("ld_req", {63'h0, dmem_req}, 64'd1);
    chk("ld_we", {63'h0, dmem_we}, 64'd0);
    chk("ld_addr", dmem_addr, 64'd8);
    tick(3);
    chk("ld_stall", {63'h0, dmem_req}, 64'd1);
    tick(1);
    chk("ld_wb_pc", nextPC, 64'd36);
    tick(1);
    chk("ld_pc", nextPC, 64'd40);
    chk("ld_ret", {32'h0, retired}, 64'd10);

    dmem_delay = 0;
    tick(3);
    chk("x5_wdata", dmem_wdata, 64'd2);
    chk("x5_addr", dmem_addr, 64'd16);
    tick(1);
    chk("x5_pc", nextPC, 64'd44);

    tick(3);
    chk("b1_pc", nextPC, 64'd56);
    chk("b1_ret", {32'h0, retired}, 64'd12);
    tick(2);
    chk("bt_hold", nextPC, 64'd56);
    tick(1);
    chk("bt_pc", nextPC, 64'd48);
    chk("bt_alu", ALUResult, 64'd0);
    chk("bt_ret", {32'h0, retired}, 64'd13);
    tick(3);
    chk("bn_pc", nextPC, 64'd52);
    chk("bn_alu", ALUResult, 64'd8);
    tick(3);
    chk("b3_pc", nextPC, 64'd64);
    tick(4);
    chk("x0w_alu", ALUResult, 64'd7);
    tick(4);
    chk("x6_alu", ALUResult, 64'd0);
    chk("x6_ret", {32'h0, retired}, 64'd17);
    tick(3);
    chk("x6_wdata", dmem_wdata, 64'd0);
    chk("x6_addr", dmem_addr, 64'd24);
    tick(1);
    chk("x6_pc", nextPC, 64'd76);

    tick(3);
    chk("ill_flag", {63'h0, illegal}, 64'd1);
    chk("ill_ireq", {63'h0, imem_req}, 64'd0);
    chk("ill_pc", nextPC, 64'd76);
    chk("ill_ret", {32'h0, retired}, 64'd18);
    chk("ill_ir", {32'h0, instruction}, 64'h7F);
    tick(5);
    chk("halt_ireq", {63'h0, imem_req}, 64'd0);
    chk("halt_ret", {32'h0, retired}, 64'd18);
    chk("halt_pc", nextPC, 64'd76);

    reset = 1'b1;
    #1;
    chk("rst2_ill", {63'h0, illegal}, 64'd0);
    chk("rst2_pc", nextPC, 64'd0);
    chk("rst2_ret", {32'h0, retired}, 64'd0);

    dmem_delay = 100;
    @(negedge clk) reset = 1'b0;
    tick(35);
    chk("stall_req", {63'h0, dmem_req}, 64'd1);
    chk("stall_ret", {32'h0, retired}, 64'd8);
    #2 reset = 1'b1;
    #1;
    chk("mrst_dreq", {63'h0, dmem_req}, 64'd0);
    chk("mrst_ireq", {63'h0, imem_req}, 64'd0);
    chk("mrst_pc", nextPC, 64'd0);
    chk("mrst_alu", ALUResult, 64'd0);
    chk("mrst_ret", {32'h0, retired}, 64'd0);
    chk("mrst_ir", {32'h0, instruction}, 64'd0);

    chk("r32_pc", {32'h0, pc32}, 64'hFFFF_FFFC);
    chk("r32_ireq", {63'h0, imem_req32}, 64'd0);
    @(negedge clk) rst32 = 1'b0;
    tick(4);
    chk("w32_pcwrap", {32'h0, pc32}, 64'd0);
    chk("w32_ret", {32'h0, ret32}, 64'd1);
    tick(8);
    chk("a32_pc", {32'h0, pc32}, 64'd8);
    chk("a32_alu", {32'h0, alu32}, 64'd2);
    chk("a32_ret", {32'h0, ret32}, 64'd3);
    tick(4);
    chk("m32_alu", {32'h0, alu32}, 64'hFFFF_FFFF);
    tick(4);
    chk("wrap32_alu", {32'h0, alu32}, 64'd0);
    chk("wrap32_pc", {32'h0, pc32}, 64'd16);
    chk("wrap32_ret", {32'h0, ret32}, 64'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
